// File: rtl/graph_mem_responder.sv
// graph_mem_responder: memory-side responder for a GraphPulse memory port.
// Each cycle it takes at most one LOAD/STORE, answers combinationally with a
// nonzero tag from a 15-entry pool, and LATENCY cycles later presents that
// tag (plus load data) on registered completion outputs for one cycle.
//
// Optional feature: define MEM_STALL_EN to add an LFSR-driven random refusal
// of commands (x^4+x^3+1, seed 4'b1001), used to exercise requester retries.
//
// Ports:
//   clock        sole clock, rising edge
//   reset        asynchronous active-low reset
//   mem_command  0 NONE, 1 LOAD, 2 STORE, 3 NONE
//   mem_addr     byte address; [2:0] byte offset, [3 +: log2(DEPTH)] word index
//   mem_st_data  store data, right-justified
//   mem_size     0 byte, 1 half, 2 word, 3 double (stores only)
//   mem_response combinational accepted tag, 0 = refused / no command
//   mem_ld_data  registered completion data (0 when mem_tag == 0)
//   mem_tag      registered completion tag, 0 = no completion
`ifndef XLEN
`define XLEN 64
`endif

module graph_mem_responder #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned DEPTH   = 256
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        mem_command,
    input  logic [`XLEN-1:0]  mem_addr,
    input  logic [63:0]       mem_st_data,
    input  logic [1:0]        mem_size,
    output logic [3:0]        mem_response,
    output logic [63:0]       mem_ld_data,
    output logic [3:0]        mem_tag
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned NTAGS = 15;
    localparam logic [1:0]  CMD_LOAD  = 2'd1;
    localparam logic [1:0]  CMD_STORE = 2'd2;

    // Tag pool: bit t-1 set means tag t is free
    logic [NTAGS-1:0] free_q, free_d;

    // Delay line; the last stage is the completion output register
    logic [3:0]  tag_q  [LATENCY];
    logic [3:0]  tag_d  [LATENCY];
    logic [63:0] data_q [LATENCY];
    logic [63:0] data_d [LATENCY];

    logic [63:0] mem_q [DEPTH];

    logic             is_req_c;
    logic             have_free_c;
    logic [3:0]       free_tag_c;
    logic             stall_c;
    logic             accept_c;
    logic [3:0]       cmp_tag_c;
    logic [IDX_W-1:0] idx_c;
    logic [63:0]      ld_word_c;
    logic [7:0]       size_mask_c;
    logic [15:0]      wr_mask_wide_c;
    logic [7:0]       wr_mask_c;
    logic [63:0]      wr_data_c;

`ifdef MEM_STALL_EN
    logic [3:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR x^4+x^3+1; refuse whenever the low two bits are zero
    always_comb begin
        lfsr_d  = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
        stall_c = (lfsr_q[1:0] == 2'b00);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr_q <= 4'b1001;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign stall_c = 1'b0;
`endif

    assign idx_c     = mem_addr[3 +: IDX_W];
    assign ld_word_c = mem_q[idx_c];
    assign cmp_tag_c = tag_q[LATENCY-1];

    // Lowest-numbered free tag and acceptance decision
    always_comb begin
        is_req_c    = (mem_command == CMD_LOAD) || (mem_command == CMD_STORE);
        have_free_c = 1'b0;
        free_tag_c  = 4'd0;
        for (int t = NTAGS; t >= 1; t--) begin
            if (free_q[t-1]) begin
                have_free_c = 1'b1;
                free_tag_c  = 4'(t);
            end
        end
        accept_c     = reset && is_req_c && have_free_c && !stall_c;
        mem_response = accept_c ? free_tag_c : 4'd0;
    end

    // Store byte lanes: shift the size mask/data to the byte offset; lanes
    // shifted past byte 7 fall off, so nothing wraps into the next word
    always_comb begin
        case (mem_size)
            2'd0:    size_mask_c = 8'h01;
            2'd1:    size_mask_c = 8'h03;
            2'd2:    size_mask_c = 8'h0F;
            default: size_mask_c = 8'hFF;
        endcase
        wr_mask_wide_c = {8'h00, size_mask_c} << mem_addr[2:0];
        wr_mask_c      = wr_mask_wide_c[7:0];
        wr_data_c      = mem_st_data << {mem_addr[2:0], 3'b000};
    end

    // Next state for tag pool and delay line
    always_comb begin
        free_d = free_q;
        for (int i = 0; i < LATENCY; i++) begin
            tag_d[i]  = 4'd0;
            data_d[i] = 64'd0;
        end
        if (accept_c) begin
            free_d[free_tag_c - 4'd1] = 1'b0;
        end
        // Completing tag frees on the edge that ends its output cycle
        if (cmp_tag_c != 4'd0) begin
            free_d[cmp_tag_c - 4'd1] = 1'b1;
        end
        tag_d[0]  = accept_c ? free_tag_c : 4'd0;
        data_d[0] = (accept_c && (mem_command == CMD_LOAD)) ? ld_word_c : 64'd0;
        for (int i = 1; i < LATENCY; i++) begin
            tag_d[i]  = tag_q[i-1];
            data_d[i] = data_q[i-1];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            free_q <= '1;
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i]  <= 4'd0;
                data_q[i] <= 64'd0;
            end
        end else begin
            free_q <= free_d;
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i]  <= tag_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    // Storage array is intentionally not reset
    always_ff @(posedge clock) begin
        if (accept_c && (mem_command == CMD_STORE)) begin
            for (int b = 0; b < 8; b++) begin
                if (wr_mask_c[b]) begin
                    mem_q[idx_c][8*b +: 8] <= wr_data_c[8*b +: 8];
                end
            end
        end
    end

    assign mem_tag     = tag_q[LATENCY-1];
    assign mem_ld_data = data_q[LATENCY-1];

    // Upper address bits alias (index wraps modulo DEPTH)
    logic unused_c;
    assign unused_c = ^{mem_addr[`XLEN-1:3+IDX_W], wr_mask_wide_c[15:8]};

endmodule

// File: tb/tb_graph_mem_responder.sv
// Bench for graph_mem_responder: directed scenarios plus random traffic,
// checked cycle by cycle against a byte-array / completion-queue model.
`ifndef XLEN
`define XLEN 64
`endif

module tb_graph_mem_responder;

    localparam int unsigned LAT = 4;
    localparam int unsigned DEP = 256;

    logic              clock = 1'b0;
    logic              reset;
    logic [1:0]        mem_command;
    logic [`XLEN-1:0]  mem_addr;
    logic [63:0]       mem_st_data;
    logic [1:0]        mem_size;
    logic [3:0]        mem_response;
    logic [63:0]       mem_ld_data;
    logic [3:0]        mem_tag;

    graph_mem_responder #(.LATENCY(LAT), .DEPTH(DEP)) dut (
        .clock       (clock),
        .reset       (reset),
        .mem_command (mem_command),
        .mem_addr    (mem_addr),
        .mem_st_data (mem_st_data),
        .mem_size    (mem_size),
        .mem_response(mem_response),
        .mem_ld_data (mem_ld_data),
        .mem_tag     (mem_tag)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          tag;
        logic [63:0] data;
        int          due;
    } cmp_t;

    logic [7:0]  mem_m [DEP*8];
    bit          busy [16];
    cmp_t        q [$];
    int          cyc;
    int          lfsr_m;
    int          total;
    int          bad;
    int          accepted;
    int          completed;
    int          dropped;
    logic [3:0]  obs_resp;
    logic [63:0] last_ld;
    int          last_exp_resp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check against model, advance model
    task automatic step(input logic rst_v, input logic [1:0] cmd, input logic [63:0] addr,
                        input logic [63:0] sd, input logic [1:0] sz);
        int          exp_tag;
        logic [63:0] exp_data;
        int          exp_resp;
        bit          stall;
        int          idx;
        int          off;
        logic [63:0] d;
        reset       = rst_v;
        mem_command = cmd;
        mem_addr    = `XLEN'(addr);
        mem_st_data = sd;
        mem_size    = sz;
        #1;
        exp_tag  = 0;
        exp_data = 64'd0;
        if (rst_v && q.size() > 0 && q[0].due == cyc) begin
            exp_tag  = q[0].tag;
            exp_data = q[0].data;
        end
        stall = 1'b0;
`ifdef MEM_STALL_EN
        stall = (lfsr_m % 4) == 0;
`endif
        exp_resp = 0;
        if (rst_v && (cmd == 2'd1 || cmd == 2'd2) && !stall) begin
            for (int t = 15; t >= 1; t--) if (!busy[t]) exp_resp = t;
        end
        chk("response", 64'(mem_response), 64'(exp_resp));
        chk("tag", 64'(mem_tag), 64'(exp_tag));
        chk("ld_data", mem_ld_data, exp_data);
        obs_resp      = mem_response;
        last_exp_resp = exp_resp;
        if (mem_tag != 4'd0) last_ld = mem_ld_data;
        if (!rst_v) begin
            dropped += q.size();
            q.delete();
            for (int t = 0; t < 16; t++) busy[t] = 1'b0;
            lfsr_m = 9;
        end else begin
            if (exp_tag != 0) begin
                busy[exp_tag] = 1'b0;
                void'(q.pop_front());
                completed++;
            end
            if (exp_resp != 0) begin
                accepted++;
                busy[exp_resp] = 1'b1;
                idx = int'((addr >> 3) % DEP);
                off = int'(addr % 8);
                d   = 64'd0;
                if (cmd == 2'd1) begin
                    for (int b = 0; b < 8; b++) d[8*b +: 8] = mem_m[idx*8 + b];
                end else begin
                    for (int k = 0; k < (1 << sz); k++)
                        if (off + k < 8) mem_m[idx*8 + off + k] = sd[8*k +: 8];
                end
                q.push_back('{exp_resp, d, cyc + int'(LAT)});
            end
            lfsr_m = ((lfsr_m << 1) & 15) | (((lfsr_m >> 3) ^ (lfsr_m >> 2)) & 1);
        end
        cyc++;
        @(posedge clock);
        #1;
    endtask

    // Issue a command, retrying while refused (bounded)
    task automatic op(input logic [1:0] cmd, input logic [63:0] addr,
                      input logic [63:0] sd, input logic [1:0] sz);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, cmd, addr, sd, sz);
            if (last_exp_resp != 0) break;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 2'd0, 64'd0, 64'd0, 2'd0);
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; lfsr_m = 9;
        accepted = 0; completed = 0; dropped = 0;
        last_ld = 64'd0; obs_resp = 4'd0; last_exp_resp = 0;
        for (int t = 0; t < 16; t++) busy[t] = 1'b0;
        reset = 1'b0; mem_command = 2'd0; mem_addr = '0; mem_st_data = 64'd0; mem_size = 2'd0;
        @(posedge clock);
        #1;

        // Reset then idle
        for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 64'd0, 64'd0, 2'd0);
        idle(10);

        // Initialise words 0..7 with full stores
        for (int w = 0; w < 8; w++) op(2'd2, 64'(w * 8), {$urandom, $urandom}, 2'd3);
        idle(LAT + 2);

        // STORE then LOAD of word 2
        op(2'd2, 64'h10, 64'hDEADBEEF_CAFEF00D, 2'd3);
`ifndef MEM_STALL_EN
        chk("store_resp", 64'(obs_resp), 64'd1);
`endif
        op(2'd1, 64'h10, 64'd0, 2'd0);
`ifndef MEM_STALL_EN
        chk("load_resp", 64'(obs_resp), 64'd2);
`endif
        idle(LAT + 1);
        chk("store_load_data", last_ld, 64'hDEADBEEF_CAFEF00D);

        // Partial half-word store at byte offset 3
        op(2'd2, 64'h13, 64'h1234, 2'd1);
        op(2'd1, 64'h10, 64'd0, 2'd0);
        idle(LAT + 1);
        chk("partial_store", last_ld, 64'hDEADBE12_34FEF00D);

        // Truncation at byte 7 and index wrap
        op(2'd2, 64'h08, 64'h11223344_55667788, 2'd3);
        op(2'd2, 64'h0F, 64'hAABBCCDD, 2'd2);
        op(2'd1, 64'h808, 64'd0, 2'd0);
        idle(LAT + 1);
        chk("trunc_wrap", last_ld, 64'hDD223344_55667788);

        // Tag recycling with back-to-back loads
        idle(LAT + 2);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 2'd1, 64'(8 * (i % 8)), 64'd0, 2'd0);
`ifndef MEM_STALL_EN
            chk("recycle_resp", 64'(obs_resp), 64'((i % 5) + 1));
`endif
        end
        idle(LAT + 2);

        // Reset in the middle of traffic drops in-flight requests
        for (int i = 0; i < 3; i++) step(1'b1, 2'd1, 64'(8 * i), 64'd0, 2'd0);
        step(1'b0, 2'd1, 64'd0, 64'd0, 2'd0);
        step(1'b0, 2'd0, 64'd0, 64'd0, 2'd0);
        idle(LAT + 2);

        // LOAD burst straight out of reset (stall pattern when enabled)
        step(1'b0, 2'd0, 64'd0, 64'd0, 2'd0);
        for (int i = 0; i < 16; i++) step(1'b1, 2'd1, 64'(8 * (i % 8)), 64'd0, 2'd0);
        idle(LAT + 2);

        // Random traffic over the initialised words, with aliased upper bits
        for (int i = 0; i < 400; i++) begin
            step(1'b1, 2'($urandom % 4),
                 64'(($urandom % 8) * 8 + ($urandom % 8) + (($urandom % 4) << 11)),
                 {$urandom, $urandom}, 2'($urandom % 4));
        end
        idle(LAT + 2);
        chk("accept_vs_complete", 64'(accepted), 64'(completed + dropped));
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
